// File: rtl/fare_pkg.sv
// Shared definitions for the fare settlement slice: FSM state encoding,
// default datapath width and the coin denominations also used by the
// coin-insertion stage.
package fare_pkg;

  localparam int FARE_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    COLLECT  = 3'd1,
    DISPENSE = 3'd2,
    CHANGE   = 3'd3,
    REFUND   = 3'd4
  } fare_state_t;

  localparam int COIN_1  = 1;
  localparam int COIN_2  = 2;
  localparam int COIN_5  = 5;
  localparam int COIN_10 = 10;

endpackage

// File: rtl/fare_change_port.sv
// Change/refund output port. A load latches the amount. A non-zero amount
// raises change_vld one cycle later, and it is held until ack is sampled.
// A zero amount is latched silently and never raises change_vld.
module fare_change_port import fare_pkg::*; #(
  parameter int DATA_W = FARE_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [DATA_W-1:0] value_i,
  input  logic              ack_i,
  output logic              vld_o,
  output logic [DATA_W-1:0] data_o,
  output logic              done_o
);

  logic              pend_q;
  logic              vld_q;
  logic [DATA_W-1:0] data_q;

  // Latch amount, raise valid a cycle later, clear everything once acked.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= 1'b0;
      vld_q  <= 1'b0;
      data_q <= '0;
    end else if (load_i) begin
      data_q <= value_i;
      pend_q <= (value_i != '0);
      vld_q  <= 1'b0;
    end else if (pend_q) begin
      pend_q <= 1'b0;
      vld_q  <= 1'b1;
    end else if (vld_q && ack_i) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end
  end

  assign vld_o  = vld_q;
  assign data_o = data_q;
  assign done_o = vld_q & ack_i;

endmodule

// File: rtl/fare_settle.sv
// Fare settlement: latches a ticket price, accumulates committed coins into
// credit, pulses ticket_out when the price is met and hands back change or a
// full refund through fare_change_port.
// Optional build macro FARE_TIMEOUT_EN adds an idle auto-refund in COLLECT.
module fare_settle import fare_pkg::*; #(
  parameter int DATA_W      = FARE_DATA_W,
  parameter int MAX_CREDIT  = 200,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              price_vld,
  input  logic [DATA_W-1:0] price_in,
  input  logic              coin_rdy,
  input  logic [DATA_W-1:0] coin_data,
  input  logic              coin_done,
  input  logic              cancel,
  input  logic              change_ack,
  output logic              busy,
  output logic [DATA_W-1:0] credit,
  output logic              coin_rej,
  output logic              ticket_out,
  output logic              change_vld,
  output logic [DATA_W-1:0] change_data
);

  localparam logic [DATA_W:0] MAX_W = (DATA_W+1)'(MAX_CREDIT);

  fare_state_t       state_q;
  logic [DATA_W-1:0] price_q;
  logic [DATA_W-1:0] credit_q;
  logic [DATA_W-1:0] shadow_q;
  logic              ticket_q;
  logic              rej_q;

  logic [DATA_W:0]   sum_d;
  logic              coin_ok_d;
  logic [DATA_W-1:0] credit_after_d;
  logic              reach_d;
  logic              refund_req_d;
  logic              timeout_hit_d;
  logic              chg_load_d;
  logic [DATA_W-1:0] chg_value_d;
  logic              chg_done;

`ifdef FARE_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  logic [TO_W-1:0] to_cnt_q;

  // Idle counter: held at zero outside COLLECT and restarted by every coin.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt_q <= '0;
    end else if (state_q != COLLECT || coin_done) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end
  end

  assign timeout_hit_d = (state_q == COLLECT) && !coin_done && (to_cnt_q == TO_LAST);
`else
  assign timeout_hit_d = 1'b0;
`endif

  // Coin commit arithmetic and change-port load selection.
  always_comb begin
    sum_d          = {1'b0, credit_q} + {1'b0, shadow_q};
    coin_ok_d      = (sum_d <= MAX_W);
    credit_after_d = (coin_done && coin_ok_d) ? sum_d[DATA_W-1:0] : credit_q;
    reach_d        = coin_done && coin_ok_d && (sum_d >= {1'b0, price_q});
    refund_req_d   = cancel | timeout_hit_d;
    chg_load_d     = 1'b0;
    chg_value_d    = '0;
    if (state_q == DISPENSE) begin
      chg_load_d  = 1'b1;
      chg_value_d = credit_q - price_q;
    end else if (state_q == COLLECT && refund_req_d) begin
      // The refund carries any coin committed in the same cycle.
      chg_load_d  = 1'b1;
      chg_value_d = credit_after_d;
    end
  end

  // Settlement FSM with price/credit/shadow registers and pulsed outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      price_q  <= '0;
      credit_q <= '0;
      shadow_q <= '0;
      ticket_q <= 1'b0;
      rej_q    <= 1'b0;
    end else begin
      ticket_q <= 1'b0;
      rej_q    <= 1'b0;
      // The done cycle carries zero data, so the coin value comes from here.
      if (coin_rdy) begin
        shadow_q <= coin_data;
      end
      case (state_q)
        IDLE: begin
          if (coin_done) begin
            rej_q <= 1'b1;
          end
          if (price_vld && price_in != '0) begin
            price_q <= price_in;
            state_q <= COLLECT;
          end
        end
        COLLECT: begin
          if (coin_done && !coin_ok_d) begin
            rej_q <= 1'b1;
          end
          if (refund_req_d) begin
            credit_q <= '0;
            state_q  <= (credit_after_d != '0) ? REFUND : IDLE;
          end else begin
            credit_q <= credit_after_d;
            if (reach_d) begin
              state_q <= DISPENSE;
            end
          end
        end
        DISPENSE: begin
          if (coin_done) begin
            rej_q <= 1'b1;
          end
          ticket_q <= 1'b1;
          credit_q <= '0;
          state_q  <= (credit_q == price_q) ? IDLE : CHANGE;
        end
        CHANGE, REFUND: begin
          if (coin_done) begin
            rej_q <= 1'b1;
          end
          if (chg_done) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  fare_change_port #(.DATA_W(DATA_W)) u_change (
    .clk     (clk),
    .rst     (rst),
    .load_i  (chg_load_d),
    .value_i (chg_value_d),
    .ack_i   (change_ack && (state_q == CHANGE || state_q == REFUND)),
    .vld_o   (change_vld),
    .data_o  (change_data),
    .done_o  (chg_done)
  );

  assign busy       = (state_q != IDLE);
  assign credit     = credit_q;
  assign coin_rej   = rej_q;
  assign ticket_out = ticket_q;

endmodule

// File: tb/tb_fare_settle.sv
// Directed bench for fare_settle (MAX_CREDIT=15, TIMEOUT_CYC=8).
module tb_fare_settle;
  import fare_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       price_vld = 1'b0;
  logic [7:0] price_in = '0;
  logic       coin_rdy = 1'b0;
  logic [7:0] coin_data = '0;
  logic       coin_done = 1'b0;
  logic       cancel = 1'b0;
  logic       change_ack = 1'b0;
  logic       busy;
  logic [7:0] credit;
  logic       coin_rej;
  logic       ticket_out;
  logic       change_vld;
  logic [7:0] change_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fare_settle #(.DATA_W(8), .MAX_CREDIT(15), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst(rst), .price_vld(price_vld), .price_in(price_in),
    .coin_rdy(coin_rdy), .coin_data(coin_data), .coin_done(coin_done),
    .cancel(cancel), .change_ack(change_ack), .busy(busy), .credit(credit),
    .coin_rej(coin_rej), .ticket_out(ticket_out), .change_vld(change_vld),
    .change_data(change_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_price(input logic [7:0] p);
    price_vld = 1'b1; price_in = p;
    tick();
    price_vld = 1'b0; price_in = '0;
  endtask

  // Full upstream report: rdy with data, then done with data forced to zero.
  task automatic send_coin(input logic [7:0] v);
    coin_rdy = 1'b1; coin_data = v;
    tick();
    coin_rdy = 1'b0; coin_data = '0; coin_done = 1'b1;
    tick();
    coin_done = 1'b0;
  endtask

  task automatic test_reset();
    tick(); tick();
    checks++;
    if ({busy, credit, coin_rej, ticket_out, change_vld, change_data} !== 20'd0) begin
      errors++; $display("FAIL reset_outputs: got %h want 0", {busy, credit, coin_rej, ticket_out, change_vld, change_data});
    end
    rst = 1'b0;
    tick();
    $display("reset released");
  endtask

  task automatic test_idle_events();
    set_price(8'd0);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL zero_price_ignored: busy=%b want 0", busy); end
    coin_done = 1'b1; tick(); coin_done = 1'b0;
    checks++;
    if (coin_rej !== 1'b1 || credit !== 8'd0) begin
      errors++; $display("FAIL idle_coin_rej: rej=%b credit=%0d want 1/0", coin_rej, credit);
    end
    tick();
    checks++;
    if (coin_rej !== 1'b0) begin errors++; $display("FAIL idle_rej_pulse: rej=%b want 0", coin_rej); end
    $display("idle events: zero price, stray coin_done");
  endtask

  task automatic test_exact_fare();
    set_price(8'd7);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL exact_busy: busy=%b want 1", busy); end
    send_coin(COIN_5[7:0]);
    checks++;
    if (credit !== 8'd5) begin errors++; $display("FAIL exact_credit5: got %0d want 5", credit); end
    send_coin(COIN_2[7:0]);
    checks++;
    if (credit !== 8'd7 || ticket_out !== 1'b0) begin
      errors++; $display("FAIL exact_credit7: credit=%0d ticket=%b want 7/0", credit, ticket_out);
    end
    tick();
    checks++;
    if (ticket_out !== 1'b1 || credit !== 8'd0) begin
      errors++; $display("FAIL exact_ticket: ticket=%b credit=%0d want 1/0", ticket_out, credit);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (ticket_out !== 1'b0 || change_vld !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL exact_idle: ticket=%b vld=%b busy=%b want 0/0/0", ticket_out, change_vld, busy);
      end
    end
    $display("exact fare: price 7, coins 5+2");
  endtask

  task automatic test_change();
    set_price(8'd3);
    send_coin(COIN_10[7:0]);
    tick();
    checks++;
    if (ticket_out !== 1'b1 || change_data !== 8'd7 || change_vld !== 1'b0) begin
      errors++; $display("FAIL change_ticket: ticket=%b data=%0d vld=%b want 1/7/0", ticket_out, change_data, change_vld);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (change_vld !== 1'b1 || change_data !== 8'd7 || ticket_out !== 1'b0) begin
        errors++; $display("FAIL change_hold: vld=%b data=%0d ticket=%b want 1/7/0", change_vld, change_data, ticket_out);
      end
    end
    change_ack = 1'b1; tick(); change_ack = 1'b0;
    checks++;
    if (change_vld !== 1'b0 || change_data !== 8'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL change_ack: vld=%b data=%0d busy=%b want 0/0/0", change_vld, change_data, busy);
    end
    $display("change: price 3, coin 10, change 7");
  endtask

  task automatic test_cancel();
    set_price(8'd20);
    send_coin(COIN_10[7:0]);
    send_coin(COIN_2[7:0]);
    checks++;
    if (credit !== 8'd12) begin errors++; $display("FAIL cancel_credit: got %0d want 12", credit); end
    cancel = 1'b1; tick(); cancel = 1'b0;
    checks++;
    if (credit !== 8'd0 || change_data !== 8'd12 || ticket_out !== 1'b0) begin
      errors++; $display("FAIL cancel_refund: credit=%0d data=%0d ticket=%b want 0/12/0", credit, change_data, ticket_out);
    end
    tick();
    checks++;
    if (change_vld !== 1'b1 || ticket_out !== 1'b0) begin
      errors++; $display("FAIL cancel_vld: vld=%b ticket=%b want 1/0", change_vld, ticket_out);
    end
    change_ack = 1'b1; tick(); change_ack = 1'b0;
    checks++;
    if (change_vld !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL cancel_done: vld=%b busy=%b want 0/0", change_vld, busy);
    end
    $display("cancel: price 20, refund 12");
  endtask

  task automatic test_overflow();
    set_price(8'd100);
    send_coin(COIN_10[7:0]);
    checks++;
    if (credit !== 8'd10 || coin_rej !== 1'b0) begin
      errors++; $display("FAIL ovf_first: credit=%0d rej=%b want 10/0", credit, coin_rej);
    end
    send_coin(COIN_10[7:0]);
    checks++;
    if (credit !== 8'd10 || coin_rej !== 1'b1) begin
      errors++; $display("FAIL ovf_reject: credit=%0d rej=%b want 10/1", credit, coin_rej);
    end
    tick();
    checks++;
    if (coin_rej !== 1'b0) begin errors++; $display("FAIL ovf_pulse: rej=%b want 0", coin_rej); end
    send_coin(COIN_5[7:0]);
    checks++;
    if (credit !== 8'd15 || coin_rej !== 1'b0) begin
      errors++; $display("FAIL ovf_at_max: credit=%0d rej=%b want 15/0", credit, coin_rej);
    end
    cancel = 1'b1; tick(); cancel = 1'b0;
    checks++;
    if (change_data !== 8'd15 || credit !== 8'd0) begin
      errors++; $display("FAIL ovf_refund: data=%0d credit=%0d want 15/0", change_data, credit);
    end
    tick();
    change_ack = 1'b1; tick(); change_ack = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL ovf_idle: busy=%b want 0", busy); end
    $display("overflow: 10+10 rejected, 10+5 accepted at ceiling");
  endtask

  task automatic test_cancel_with_coin();
    set_price(8'd5);
    coin_rdy = 1'b1; coin_data = COIN_5[7:0]; tick();
    coin_rdy = 1'b0; coin_data = '0; coin_done = 1'b1; cancel = 1'b1; tick();
    coin_done = 1'b0; cancel = 1'b0;
    checks++;
    if (credit !== 8'd0 || change_data !== 8'd5 || ticket_out !== 1'b0) begin
      errors++; $display("FAIL coincident_refund: credit=%0d data=%0d ticket=%b want 0/5/0", credit, change_data, ticket_out);
    end
    tick();
    checks++;
    if (change_vld !== 1'b1 || ticket_out !== 1'b0) begin
      errors++; $display("FAIL coincident_vld: vld=%b ticket=%b want 1/0", change_vld, ticket_out);
    end
    change_ack = 1'b1; tick(); change_ack = 1'b0;
    checks++;
    if (busy !== 1'b0 || change_vld !== 1'b0) begin
      errors++; $display("FAIL coincident_done: busy=%b vld=%b want 0/0", busy, change_vld);
    end
    $display("coin_done with cancel: refund 5, no ticket");
  endtask

  task automatic test_reset_midway();
    set_price(8'd9);
    send_coin(COIN_5[7:0]);
    checks++;
    if (credit !== 8'd5) begin errors++; $display("FAIL midrst_credit: got %0d want 5", credit); end
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({busy, credit, coin_rej, ticket_out, change_vld, change_data} !== 20'd0) begin
      errors++; $display("FAIL midrst_async: got %h want 0", {busy, credit, coin_rej, ticket_out, change_vld, change_data});
    end
    #1 rst = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || ticket_out !== 1'b0 || credit !== 8'd0) begin
      errors++; $display("FAIL midrst_after: busy=%b ticket=%b credit=%0d want 0/0/0", busy, ticket_out, credit);
    end
    $display("reset mid-COLLECT");
  endtask

`ifdef FARE_TIMEOUT_EN
  task automatic test_timeout();
    bit seen;
    set_price(8'd9);
    send_coin(COIN_2[7:0]);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (change_vld === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen || change_data !== 8'd2 || credit !== 8'd0) begin
      errors++; $display("FAIL timeout_refund: seen=%b data=%0d credit=%0d want 1/2/0", seen, change_data, credit);
    end
    change_ack = 1'b1; tick(); change_ack = 1'b0;
    set_price(8'd9);
    for (int i = 0; i < 12; i++) tick();
    checks++;
    if (busy !== 1'b0 || change_vld !== 1'b0) begin
      errors++; $display("FAIL timeout_silent: busy=%b vld=%b want 0/0", busy, change_vld);
    end
    $display("timeout: auto-refund 2, silent zero-credit return");
  endtask
`endif

  initial begin
    test_reset();
    test_idle_events();
    test_exact_fare();
    test_change();
    test_cancel();
    test_overflow();
    test_cancel_with_coin();
    test_reset_midway();
`ifdef FARE_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fare_settle.md
Name: fare_settle

Overview:
- Sits directly downstream of the coin-insertion stage and consumes its three-signal coin report: ready, data, complete.
- Holds the selected ticket price and accumulates inserted coin values into a credit register.
- Issues a one-cycle ticket-dispense pulse once credit ≥ price, then presents change (credit − price) over a valid/ack handshake.
- Supports cancel/refund of the full credit and rejects coins that would exceed the credit ceiling.

Parameters:
- DATA_W, 8, width of coin, price, credit and change values.
- MAX_CREDIT, 200, highest credit the block accepts; must be < 2**DATA_W.
- TIMEOUT_CYC, 1000, idle cycles in COLLECT before auto-refund (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- price_vld  in  1  one-cycle strobe; price_in valid
- price_in  in  DATA_W  selected ticket price
- coin_rdy  in  1  upstream coin report in progress
- coin_data  in  DATA_W  upstream coin value; valid on the last cycle coin_rdy=1
- coin_done  in  1  one-cycle pulse; upstream report complete
- cancel  in  1  one-cycle passenger cancel request
- change_ack  in  1  change consumer accepted change_data
- busy  out  1  high in any state other than IDLE
- credit  out  DATA_W  current accumulated credit
- coin_rej  out  1  one-cycle pulse; last coin refused (overflow)
- ticket_out  out  1  one-cycle dispense pulse
- change_vld  out  1  change_data valid; held until ack
- change_data  out  DATA_W  change or refund amount

Behaviour:
- Reset values: all outputs 0; state IDLE; internal price, credit and shadow registers 0.
- Coin capture:
  - Shadow register loads coin_data on every cycle coin_rdy=1.
  - On coin_done=1, shadow is committed. Upstream forces data to 0 in the done cycle, so coin_data is never sampled directly at done.
- States IDLE, COLLECT, DISPENSE, CHANGE, REFUND:
  - IDLE:
    - On price_vld with price_in≠0: latch price, go to COLLECT.
    - price_in=0: ignored, stay IDLE.
    - coin_done in IDLE: coin_rej pulse, credit unchanged.
  - COLLECT, on coin_done:
    - sum = credit + shadow, computed DATA_W+1 bits wide.
    - sum > MAX_CREDIT: coin_rej pulse the next cycle, credit unchanged.
    - Otherwise credit ← sum. If sum ≥ price, go to DISPENSE the next cycle.
  - DISPENSE:
    - ticket_out=1 for exactly one cycle.
    - Latch change_data ← credit − price; clear credit.
    - If the change is 0, go to IDLE; else go to CHANGE.
  - CHANGE:
    - change_vld=1 and change_data held stable until change_ack=1 is sampled.
    - Then change_vld←0, change_data←0, go to IDLE.
  - REFUND:
    - Entered from COLLECT on cancel.
    - change_data ← credit; credit ← 0.
    - If the refund is 0, go straight to IDLE with no change_vld; else handshake as in CHANGE.
- Latency:
  - Qualifying coin_done → ticket_out: 2 cycles (edge 1 updates credit, edge 2 asserts ticket_out).
  - change_vld asserts the cycle after ticket_out.
- Simultaneous events:
  - cancel + coin_done in COLLECT: coin committed first (subject to the overflow rule), then the full credit is refunded. No ticket, even if the price is reached.
  - cancel outside COLLECT: ignored.
  - price_vld while busy: ignored.
  - change_ack outside CHANGE/REFUND: ignored.
  - coin_done in DISPENSE/CHANGE/REFUND: coin_rej pulse, credit unchanged.
- Reset mid-operation: immediate return to IDLE; credit and change are discarded; no ticket or change is issued.
- Price is never modified after latching; credit never exceeds MAX_CREDIT.

Optional Feature:
- FARE_TIMEOUT_EN defined:
  - A counter clears on entry to COLLECT and on each coin_done, and increments every COLLECT cycle.
  - When it reaches TIMEOUT_CYC−1, the block enters REFUND exactly as for cancel.
  - Zero credit returns to IDLE silently.
- Not defined: no counter is synthesised; COLLECT waits indefinitely.

Decomposition:
- Shared package fare_pkg:
  - state encoding constants: IDLE=3'd0, COLLECT=3'd1, DISPENSE=3'd2, CHANGE=3'd3, REFUND=3'd4;
  - DATA_W default;
  - coin denomination constants 1, 2, 5, 10, shared with the coin-insertion stage.
- One natural sub-module, fare_change_port: holds change_vld/change_data and the ack handshake, reused by CHANGE and REFUND.
- The FSM and accumulator stay in the top level.

Test Plan:
- Price 7; coins 5 then 2 via the full upstream sequence → credit 5, then 7; ticket_out 2 cycles after the second coin_done; change_vld never asserts; back to IDLE.
- Price 3; coin 10 → ticket_out; change_vld=1 with change_data=7 held; ack delayed 5 cycles; change_vld drops the cycle after ack.
- Price 20; coins 10+2, then cancel → change_data=12; no ticket_out; credit=0.
- MAX_CREDIT=15, price 100; coins 10, then 10 → second coin_rej pulse; credit stays 10.
- Price 5; coin 5 with coin_done coincident with cancel → no ticket; refund of 5.
- Price 9; coin 5; rst asserted mid-COLLECT → all outputs 0 asynchronously; FARE_TIMEOUT_EN build with TIMEOUT_CYC=8 and no coins after a coin 2 → auto-refund of 2.
